// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with stall/flush/valid (clk, rst_n, stall, flush, valid_in, pc_in, pc_next_in, inst_in -> valid_out, pc_out, pc_next_out, inst_out); stall_cnt/flush_cnt perf counters live only with IFID_PERF_CNT_EN defined
module if_id_pipe_reg #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_INST = 32'h0000_0013,
  parameter logic [DATA_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter int                 CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] pc_next_in,
  input  logic [DATA_W-1:0] inst_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pc_next_out,
  output logic [DATA_W-1:0] inst_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_out   <= 1'b0;
      pc_out      <= RESET_PC;
      pc_next_out <= RESET_PC;
      inst_out    <= NOP_INST;
    end else if (flush) begin
      valid_out   <= 1'b0;
      pc_out      <= RESET_PC;
      pc_next_out <= RESET_PC;
      inst_out    <= NOP_INST;
    end else if (!stall) begin
      valid_out   <= valid_in;
      pc_out      <= pc_in;
      pc_next_out <= pc_next_in;
      inst_out    <= valid_in ? inst_in : NOP_INST;
    end
`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= (stall && !flush && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= (flush && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
    end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
